// File: rtl/mult32_seq_pkg.sv
// Shared constants and FSM state type for the sequential 32x32 multiplier.
package mult32_seq_pkg;

    localparam int OP_WIDTH   = 32;
    localparam int PROD_WIDTH = 2 * OP_WIDTH;
    localparam int CNT_WIDTH  = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIX  = 2'd2
    } state_e;

endpackage

// File: rtl/mult32_seq_adder32.sv
// 32-bit ripple-style adder with carry-in and carry-out, shared by the multiplier datapath.
module adder32
    import mult32_seq_pkg::*;
(
    input  logic [OP_WIDTH-1:0] a_i,
    input  logic [OP_WIDTH-1:0] b_i,
    input  logic                cin_i,
    output logic [OP_WIDTH-1:0] sum_o,
    output logic                cout_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{OP_WIDTH{1'b0}}, cin_i};

endmodule

// File: rtl/mult32_seq.sv
// Sequential shift-add 32x32 multiplier (MIPS mult/multu): 32 add/shift cycles on
// operand magnitudes, then one cycle of sign correction that commits {HI,LO}.
module mult32_seq
    import mult32_seq_pkg::*;
#(
    parameter int WIDTH = OP_WIDTH
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);

    state_e                state_q, state_d;
    logic [OP_WIDTH-1:0]   mcand_q, mcand_d;
    logic [OP_WIDTH-1:0]   mplier_q, mplier_d;
    logic [PROD_WIDTH-1:0] acc_q, acc_d;
    logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  sign_q, sign_d;
    logic [OP_WIDTH-1:0]   hi_q, hi_d;
    logic [OP_WIDTH-1:0]   lo_q, lo_d;
    logic                  done_q, done_d;

    logic [OP_WIDTH-1:0] a_inv_plus1, b_inv_plus1;
    logic [OP_WIDTH-1:0] mag_a, mag_b;
    logic [OP_WIDTH-1:0] pp_addend, pp_sum;
    logic                pp_cout;
    logic [OP_WIDTH-1:0] neg_lo, neg_hi;
    logic                neg_lo_cout;
    logic                a_cout, b_cout, neg_hi_cout;
    logic                unused_carries;

    // Magnitudes by invert-plus-one; 0x80000000 maps onto itself, read as unsigned.
    adder32 u_mag_a (
        .a_i    (~A),
        .b_i    ('0),
        .cin_i  (1'b1),
        .sum_o  (a_inv_plus1),
        .cout_o (a_cout)
    );

    adder32 u_mag_b (
        .a_i    (~B),
        .b_i    ('0),
        .cin_i  (1'b1),
        .sum_o  (b_inv_plus1),
        .cout_o (b_cout)
    );

    assign mag_a = (is_signed && A[OP_WIDTH-1]) ? a_inv_plus1 : A;
    assign mag_b = (is_signed && B[OP_WIDTH-1]) ? b_inv_plus1 : B;

    assign pp_addend = mplier_q[0] ? mcand_q : '0;

    adder32 u_pp (
        .a_i    (acc_q[PROD_WIDTH-1:OP_WIDTH]),
        .b_i    (pp_addend),
        .cin_i  (1'b0),
        .sum_o  (pp_sum),
        .cout_o (pp_cout)
    );

    // 64-bit two's-complement negation of the accumulator, carry chained between halves.
    adder32 u_neg_lo (
        .a_i    (~acc_q[OP_WIDTH-1:0]),
        .b_i    ('0),
        .cin_i  (1'b1),
        .sum_o  (neg_lo),
        .cout_o (neg_lo_cout)
    );

    adder32 u_neg_hi (
        .a_i    (~acc_q[PROD_WIDTH-1:OP_WIDTH]),
        .b_i    ('0),
        .cin_i  (neg_lo_cout),
        .sum_o  (neg_hi),
        .cout_o (neg_hi_cout)
    );

    assign unused_carries = a_cout ^ b_cout ^ neg_hi_cout;

    always_comb begin
        // NOTE: every next-state signal gets a default first so no path leaves it unassigned (no latches).
        state_d  = state_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    mcand_d  = mag_a;
                    mplier_d = mag_b;
                    sign_d   = is_signed & (A[OP_WIDTH-1] ^ B[OP_WIDTH-1]);
                    acc_d    = '0;
                    cnt_d    = '0;
                    state_d  = RUN;
                end
            end
            RUN: begin
                // Shift {carry, sum, acc_lo, mplier} right by one; product bits collect in acc.
                acc_d    = {pp_cout, pp_sum, acc_q[OP_WIDTH-1:1]};
                mplier_d = {acc_q[0], mplier_q[OP_WIDTH-1:1]};
                cnt_d    = cnt_q + 5'd1;
                if (cnt_q == 5'd31) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                {hi_d, lo_d} = sign_q ? {neg_hi, neg_lo} : acc_q;
                done_d       = 1'b1;
                state_d      = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            sign_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            sign_q   <= sign_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign HI   = hi_q;
    assign LO   = lo_q;

endmodule
